// File: rtl/debounce_edge_if.sv
// Signal bundle between the synchronizer-side producer and the debouncer.
// The master drives the synchronized input and the slave returns the cleaned level and strobes.
interface debounce_edge_if;
  logic D;
  logic level;
  logic rise;
  logic fall;
  logic busy;

  modport master (
    output D,
    input  level,
    input  rise,
    input  fall,
    input  busy
  );

  modport slave (
    input  D,
    output level,
    output rise,
    output fall,
    output busy
  );
endinterface

// File: rtl/debounce_edge.sv
// Debounces an already-synchronized input into a clean level with one-cycle rise/fall strobes.
// A change is accepted only after STABLE_CYCLES consecutive samples that differ from the level.
module debounce_edge #(
  parameter int unsigned STABLE_CYCLES = 1000,
  parameter int unsigned CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
  input  logic            clk,
  input  logic            reset,
  debounce_edge_if.slave  bus
);

  typedef enum logic [1:0] {StIdleLow, StWaitHigh, StIdleHigh, StWaitLow} state_t;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(STABLE_CYCLES - 1);
  localparam logic             Single  = (STABLE_CYCLES == 1);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             level_q;
  logic             rise_q;
  logic             fall_q;
  logic             busy_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdleLow;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      // Strobes last exactly one cycle; only an accepting branch re-raises them.
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      unique case (state_q)
        StIdleLow: begin
          if (bus.D) begin
            if (Single) begin
              state_q <= StIdleHigh;
              cnt_q   <= '0;
              level_q <= 1'b1;
              rise_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              state_q <= StWaitHigh;
              cnt_q   <= CNT_W'(1);
              busy_q  <= 1'b1;
            end
          end
        end
        StWaitHigh: begin
          if (!bus.D) begin
            state_q <= StIdleLow;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else if (cnt_q == CntLast) begin
            state_q <= StIdleHigh;
            cnt_q   <= '0;
            level_q <= 1'b1;
            rise_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        StIdleHigh: begin
          if (!bus.D) begin
            if (Single) begin
              state_q <= StIdleLow;
              cnt_q   <= '0;
              level_q <= 1'b0;
              fall_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              state_q <= StWaitLow;
              cnt_q   <= CNT_W'(1);
              busy_q  <= 1'b1;
            end
          end
        end
        StWaitLow: begin
          if (bus.D) begin
            state_q <= StIdleHigh;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else if (cnt_q == CntLast) begin
            state_q <= StIdleLow;
            cnt_q   <= '0;
            level_q <= 1'b0;
            fall_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= StIdleLow;
          cnt_q   <= '0;
          level_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.level = level_q;
  assign bus.rise  = rise_q;
  assign bus.fall  = fall_q;
  assign bus.busy  = busy_q;

endmodule

// File: tb/tb_debounce_edge.sv
// Directed bench for debounce_edge with STABLE_CYCLES=4 and STABLE_CYCLES=1 instances.
// Expected {level,rise,fall,busy} vectors are queued on each step and compared after the edge.
module tb_debounce_edge;
  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  debounce_edge_if bus4 ();
  debounce_edge_if bus1 ();

  debounce_edge #(.STABLE_CYCLES(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4.slave)
  );

  debounce_edge #(.STABLE_CYCLES(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1.slave)
  );

  typedef struct {
    string      tag;
    bit         sel;
    logic [3:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic push(input bit sel, input logic [3:0] exp, input string tag);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t       e;
    logic [3:0] obs;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard: observed=empty queue expected=entry");
    end else begin
      e = sb.pop_front();
      obs = e.sel ? {bus1.level, bus1.rise, bus1.fall, bus1.busy}
                  : {bus4.level, bus4.rise, bus4.fall, bus4.busy};
      assert (obs === e.exp) else begin
        errors++;
        $error("FAIL %s: observed {level,rise,fall,busy}=%b expected=%b", e.tag, obs, e.exp);
      end
    end
  endtask

  // Drive D on the selected instance, queue the result expected after the next edge, check it.
  task automatic step(input bit sel, input logic d, input logic [3:0] exp, input string tag);
    if (sel) bus1.D = d;
    else     bus4.D = d;
    push(sel, exp, tag);
    @(posedge clk);
    #1;
    check_out();
  endtask

  initial begin
    reset   = 1'b1;
    bus4.D  = 1'b0;
    bus1.D  = 1'b0;
    #12;
    push(1'b0, 4'b0000, "reset4");
    check_out();
    push(1'b1, 4'b0000, "reset1");
    check_out();
    reset = 1'b0;

    // Clean rise: D high from edge 2, accepted at edge 5.
    step(1'b0, 1'b0, 4'b0000, "t1_e1");
    step(1'b0, 1'b1, 4'b0001, "t1_e2");
    step(1'b0, 1'b1, 4'b0001, "t1_e3");
    step(1'b0, 1'b1, 4'b0001, "t1_e4");
    step(1'b0, 1'b1, 4'b1100, "t1_e5_rise");
    step(1'b0, 1'b1, 4'b1000, "t1_e6_norise");

    // Fall with an aborted first burst: 0,0,0,1,0,0,0,0.
    step(1'b0, 1'b0, 4'b1001, "t2_p1");
    step(1'b0, 1'b0, 4'b1001, "t2_p2");
    step(1'b0, 1'b0, 4'b1001, "t2_p3");
    step(1'b0, 1'b1, 4'b1000, "t2_p4_abort");
    step(1'b0, 1'b0, 4'b1001, "t2_p5");
    step(1'b0, 1'b0, 4'b1001, "t2_p6");
    step(1'b0, 1'b0, 4'b1001, "t2_p7");
    step(1'b0, 1'b0, 4'b0010, "t2_p8_fall");
    step(1'b0, 1'b0, 4'b0000, "t2_p9_nofall");

    // Bounce from IDLE_LOW: 1,0,1,1,0,1,1,1,0 never reaches four in a row.
    step(1'b0, 1'b1, 4'b0001, "t3_b1");
    step(1'b0, 1'b0, 4'b0000, "t3_b2");
    step(1'b0, 1'b1, 4'b0001, "t3_b3");
    step(1'b0, 1'b1, 4'b0001, "t3_b4");
    step(1'b0, 1'b0, 4'b0000, "t3_b5");
    step(1'b0, 1'b1, 4'b0001, "t3_b6");
    step(1'b0, 1'b1, 4'b0001, "t3_b7");
    step(1'b0, 1'b1, 4'b0001, "t3_b8");
    step(1'b0, 1'b0, 4'b0000, "t3_b9");

    // Asynchronous reset in the middle of WAIT_HIGH.
    step(1'b0, 1'b1, 4'b0001, "t5_s1");
    step(1'b0, 1'b1, 4'b0001, "t5_s2");
    step(1'b0, 1'b1, 4'b0001, "t5_s3");
    #2;
    reset = 1'b1;
    #1;
    push(1'b0, 4'b0000, "t5_async_clear");
    check_out();
    reset = 1'b0;
    step(1'b0, 1'b1, 4'b0001, "t5_r1");
    step(1'b0, 1'b1, 4'b0001, "t5_r2");
    step(1'b0, 1'b1, 4'b0001, "t5_r3");
    step(1'b0, 1'b1, 4'b1100, "t5_r4_rise");

    // Reset during the rise strobe cycle, then full requalification.
    #2;
    reset = 1'b1;
    #1;
    push(1'b0, 4'b0000, "t6_strobe_clear");
    check_out();
    reset = 1'b0;
    step(1'b0, 1'b1, 4'b0001, "t6_q1");
    step(1'b0, 1'b1, 4'b0001, "t6_q2");
    step(1'b0, 1'b1, 4'b0001, "t6_q3");
    step(1'b0, 1'b1, 4'b1100, "t6_q4_rise");
    step(1'b0, 1'b1, 4'b1000, "t6_q5");

    // STABLE_CYCLES=1: every change of D lands on the next edge with a strobe.
    bus4.D = 1'b0;
    step(1'b1, 1'b0, 4'b0000, "t4_d0");
    step(1'b1, 1'b1, 4'b1100, "t4_rise1");
    step(1'b1, 1'b0, 4'b0010, "t4_fall1");
    step(1'b1, 1'b1, 4'b1100, "t4_rise2");
    step(1'b1, 1'b0, 4'b0010, "t4_fall2");
    step(1'b1, 1'b1, 4'b1100, "t4_rise3");
    step(1'b1, 1'b1, 4'b1000, "t4_hold");
    step(1'b1, 1'b0, 4'b0010, "t4_fall3");
    step(1'b1, 1'b0, 4'b0000, "t4_idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
